ustcpv_memarb: RTL and testbench
================================

# ustcpv_memarb

Single-port memory sequencer for the `ustcpv` core. The core has separate instruction and data ports and expects both to answer in the same cycle. This block sits between the core and one shared memory port, serialises the data access and the instruction fetch of each core cycle, and stalls the core through `HLT` until both are complete. It also provides a bus-timeout watchdog, a sticky error flag and a stall-cycle counter.

## Interface
- `TIMEOUT`, 255: maximum cycles `MRD`/`MWR` may wait for `MACK` before the access is aborted; 0 disables the watchdog.
- `CLK` input 1: clock; all state changes on the rising edge.
- `RESN` input 1: reset, asynchronous, active-low.
- `HLTI` input 1: external freeze request (debugger); sampled only in IDLE.
- `IADDR` input 32: core fetch address.
- `IDATA` output 32: fetched instruction returned to the core.
- `DADDR` input 32: core data address.
- `DATAO` input 32: core store data, already lane-shifted.
- `DATAI` output 32: load data returned to the core.
- `RD` input 1: core load request.
- `WR` input 1: core store request.
- `HLT` output 1: core stall; the core advances only in cycles where `HLT`=0.
- `MADDR` output 32: memory address.
- `MDATAO` output 32: memory write data.
- `MDATAI` input 32: memory read data; valid when `MACK`=1.
- `MRD` output 1: memory read strobe.
- `MWR` output 1: memory write strobe.
- `MACK` input 1: memory completion; may be asserted in the same cycle as the strobe.
- `ERR` output 1: sticky timeout flag.
- `STALLS` output 32: count of cycles with `HLT`=1.

## Operation
- **FSM states:** IDLE, DMEM, IMEM, RUN.
- **IDLE** (`HLT`=1, no strobe):
  - `HLTI`=1: stay in IDLE.
  - `RD` or `WR` asserted: go to DMEM.
  - Otherwise: go to IMEM.
- **DMEM:**
  - Drive `MADDR`=`DADDR`, `MDATAO`=`DATAO`, `MWR`=`WR`, `MRD`=`RD & !WR`. If both `RD` and `WR` are asserted, the write takes priority.
  - Hold the strobe until `MACK`. On `MACK` with a read, capture `MDATAI` into `DBUF`. Then go to IMEM.
- **IMEM:**
  - Drive `MADDR`=`IADDR`, `MRD`=1.
  - On `MACK`, capture `MDATAI` into `IBUF`, then go to RUN.
- **RUN:**
  - `HLT`=0 for exactly one cycle; the core consumes `IDATA`=`IBUF` and `DATAI`=`DBUF`.
  - Next state is always IDLE.
- **Ordering:** within one core cycle the data access precedes the fetch, so a store followed by a fetch of the same word returns the new value.
- **Write count:** each store is written exactly once per core cycle. The core holds `DADDR`/`DATAO`/`WR` stable while `HLT`=1.
- **Byte enables:** writes are full-word. Partial-store lane masking is out of scope for this block.
- **Watchdog:**
  - A counter clears on entry to DMEM or IMEM and increments each cycle the strobe is high without `MACK`.
  - When the counter reaches `TIMEOUT` (and `TIMEOUT` is non-zero), the access completes as if `MACK` had arrived. Read data is 32'h0, `ERR` sets, and the FSM advances normally.
  - `ERR` clears only on reset.
- **STALLS:** increments every cycle `HLT`=1 and wraps from 32'hFFFFFFFF to 0.
- **Outputs are registered:** `IDATA` and `DATAI` come from `IBUF` and `DBUF`, which hold their values until the next capture.

## Timing
- **Reset values** (`RESN`=0): state IDLE, `HLT`=1, `MRD`=`MWR`=0, `IBUF`=`DBUF`=0, `ERR`=0, `STALLS`=0, watchdog counter 0.
- **Reset mid-access:** takes effect immediately. Strobes drop asynchronously and the pending access is abandoned.
- **Combinational outputs:**
  - `MADDR`, `MDATAO`, `MRD` and `MWR` decode from the state and the core inputs. They are not registered.
  - `HLT` is a pure decode of state: 0 only in RUN.
- **Zero-wait memory** (`MACK` in the strobe cycle):
  - 3 cycles per core cycle without a data access (IDLE, IMEM, RUN).
  - 4 cycles per core cycle with a data access.
- **Wait states:** each cycle of `MACK` latency adds one cycle.
- **Watchdog timing:** a timed-out access occupies `TIMEOUT`+1 cycles in its state.
- **Spurious `MACK`:** `MACK` in IDLE or RUN is ignored.
- **`HLTI` timing:** `HLTI` asserted during DMEM, IMEM or RUN has no effect until the FSM next reaches IDLE.

## Test plan
- **Fetch only, zero-wait memory.** `MACK` tied to 1, `RD`=`WR`=0, `IADDR`=0x100, `MDATAI`=0x00500093.
  - `MRD`=1 with `MADDR`=0x100 one cycle after IDLE.
  - `HLT`=0 on the third cycle with `IDATA`=0x00500093.
  - `STALLS` increments by 2 per core cycle.
- **Load then fetch with 2-wait memory.** `RD`=1, `DADDR`=0x2000, read data 0xCAFEBABE.
  - DMEM lasts 3 cycles, then IMEM lasts 3 cycles.
  - `HLT`=0 for one cycle with `DATAI`=0xCAFEBABE.
- **Store, then fetch of the same word.** `WR`=1, `DADDR`=0x40, `DATAO`=0x12345678, then `IADDR`=0x40 against a memory model.
  - Exactly one `MWR` pulse, with `MDATAO`=0x12345678.
  - `IDATA`=0x12345678.
- **Timeout.** `TIMEOUT`=4, `MACK` held at 0 during IMEM.
  - Strobe stays high for 5 cycles, then the FSM enters RUN with `IDATA`=0 and `ERR`=1.
  - `ERR` stays 1 until `RESN` pulses low.
- **Reset mid-DMEM and `HLTI`.**
  - `RESN` low during a pending `MWR`: `MWR` falls in the same cycle and all outputs take their reset values.
  - After release, `HLTI`=1 holds the FSM in IDLE with `HLT`=1 and `STALLS` incrementing. `HLTI`=0 resumes with IMEM.

Source files
------------

// File: rtl/ustcpv_memarb.sv
// Shares one memory port between the ustcpv data and instruction ports.
// Each core cycle runs the data access first, then the fetch, and stalls the core via HLT until both are done.
module ustcpv_memarb #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESN,
    input  logic        HLTI,
    input  logic [31:0] IADDR,
    output logic [31:0] IDATA,
    input  logic [31:0] DADDR,
    input  logic [31:0] DATAO,
    output logic [31:0] DATAI,
    input  logic        RD,
    input  logic        WR,
    output logic        HLT,
    output logic [31:0] MADDR,
    output logic [31:0] MDATAO,
    input  logic [31:0] MDATAI,
    output logic        MRD,
    output logic        MWR,
    input  logic        MACK,
    output logic        ERR,
    output logic [31:0] STALLS
);

    // state | meaning
    // IDLE  | core stalled, no strobe; waits out HLTI, picks data or fetch
    // DMEM  | data load/store on the memory port
    // IMEM  | instruction fetch on the memory port
    // RUN   | HLT low for one cycle, core consumes IBUF/DBUF
    typedef enum logic [1:0] {S_IDLE, S_DMEM, S_IMEM, S_RUN} state_t;

    state_t      state_q, state_d;
    logic [31:0] ibuf_q, ibuf_d;
    logic [31:0] dbuf_q, dbuf_d;
    logic        err_q, err_d;
    logic [31:0] wdog_q, wdog_d;
    logic [31:0] stalls_q, stalls_d;
    logic        wd_expired;

    assign wd_expired = (TIMEOUT != 32'd0) && (wdog_q == TIMEOUT);

    always_comb begin
        state_d  = state_q;
        ibuf_d   = ibuf_q;
        dbuf_d   = dbuf_q;
        err_d    = err_q;
        wdog_d   = wdog_q;
        stalls_d = stalls_q + {31'd0, (state_q != S_RUN)};
        MADDR    = 32'd0;
        MDATAO   = 32'd0;
        MRD      = 1'b0;
        MWR      = 1'b0;
        HLT      = (state_q != S_RUN);

        case (state_q)
            S_IDLE: begin
                if (!HLTI) begin
                    wdog_d  = 32'd0;
                    state_d = (RD || WR) ? S_DMEM : S_IMEM;
                end
            end
            S_DMEM: begin
                MADDR  = DADDR;
                MDATAO = DATAO;
                MWR    = WR;
                MRD    = RD & ~WR;
                // Request withdrawn mid-access: nothing to complete, move on to the fetch.
                if (!(RD || WR)) begin
                    wdog_d  = 32'd0;
                    state_d = S_IMEM;
                end else if (MACK || wd_expired) begin
                    if (!WR) dbuf_d = MACK ? MDATAI : 32'd0;
                    if (!MACK) err_d = 1'b1;
                    wdog_d  = 32'd0;
                    state_d = S_IMEM;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
            S_IMEM: begin
                MADDR = IADDR;
                MRD   = 1'b1;
                if (MACK || wd_expired) begin
                    ibuf_d = MACK ? MDATAI : 32'd0;
                    if (!MACK) err_d = 1'b1;
                    wdog_d  = 32'd0;
                    state_d = S_RUN;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
            S_RUN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            state_q  <= S_IDLE;
            ibuf_q   <= 32'd0;
            dbuf_q   <= 32'd0;
            err_q    <= 1'b0;
            wdog_q   <= 32'd0;
            stalls_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            ibuf_q   <= ibuf_d;
            dbuf_q   <= dbuf_d;
            err_q    <= err_d;
            wdog_q   <= wdog_d;
            stalls_q <= stalls_d;
        end
    end

    assign IDATA  = ibuf_q;
    assign DATAI  = dbuf_q;
    assign ERR    = err_q;
    assign STALLS = stalls_q;

endmodule

// File: tb/tb_ustcpv_memarb.sv
// Directed bench for ustcpv_memarb: a small word memory with configurable ACK latency answers the shared port.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ustcpv_memarb;

    logic        CLK = 1'b0;
    logic        RESN;
    logic        HLTI;
    logic [31:0] IADDR, IDATA, DADDR, DATAO, DATAI;
    logic        RD, WR, HLT;
    logic [31:0] MADDR, MDATAO, MDATAI;
    logic        MRD, MWR, MACK, ERR;
    logic [31:0] STALLS;

    logic [31:0] mem [0:255];
    int          wait_cfg;
    int          wcnt;
    logic        ack_en;
    logic        mack_force;
    int          wr_count;
    int          checks = 0;
    int          errors = 0;

    ustcpv_memarb #(.TIMEOUT(4)) dut (
        .CLK(CLK), .RESN(RESN), .HLTI(HLTI),
        .IADDR(IADDR), .IDATA(IDATA),
        .DADDR(DADDR), .DATAO(DATAO), .DATAI(DATAI),
        .RD(RD), .WR(WR), .HLT(HLT),
        .MADDR(MADDR), .MDATAO(MDATAO), .MDATAI(MDATAI),
        .MRD(MRD), .MWR(MWR), .MACK(MACK),
        .ERR(ERR), .STALLS(STALLS)
    );

    always #5 CLK = ~CLK;

    assign MDATAI = mem[MADDR[9:2]];
    assign MACK   = mack_force | (ack_en & (MRD | MWR) & (wcnt == wait_cfg));

    always @(posedge CLK) begin
        if ((MRD || MWR) && !MACK) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (MWR && MACK) begin
            mem[MADDR[9:2]] <= MDATAO;
            wr_count        <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Steps falling edges until HLT drops; returns stalled cycles and strobe-cycle counts.
    task automatic run_core(output int cyc, output int nrd, output int nwr, output logic [31:0] wdat);
        cyc = 0; nrd = 0; nwr = 0; wdat = 32'hx;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (HLT == 1'b0) return;
            cyc++;
            if (MRD) nrd++;
            if (MWR) begin
                nwr++;
                wdat = MDATAO;
            end
        end
        chk("run_core_budget", 32'd0, 32'd1);
    endtask

    int          cyc, nrd, nwr;
    logic [31:0] wdat;
    int          wr0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'h00500093;
        mem[8'h00] = 32'hCAFEBABE;
        mem[8'h10] = 32'hDEADBEEF;
        wait_cfg = 0; wcnt = 0; ack_en = 1'b1; mack_force = 1'b0; wr_count = 0;
        RESN = 1'b0; HLTI = 1'b0; RD = 1'b0; WR = 1'b0;
        IADDR = 32'h100; DADDR = 32'h0; DATAO = 32'h0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_hlt", {31'd0, HLT}, 32'd1);
        chk("rst_strobes", {30'd0, MRD, MWR}, 32'd0);
        chk("rst_idata", IDATA, 32'd0);
        chk("rst_datai", DATAI, 32'd0);
        chk("rst_err", {31'd0, ERR}, 32'd0);
        chk("rst_stalls", STALLS, 32'd0);
        RESN = 1'b1;

        // fetch only, zero-wait
        @(negedge CLK);
        chk("f_mrd", {31'd0, MRD}, 32'd1);
        chk("f_maddr", MADDR, 32'h100);
        chk("f_hlt_imem", {31'd0, HLT}, 32'd1);
        @(negedge CLK);
        chk("f_hlt_run", {31'd0, HLT}, 32'd0);
        chk("f_idata", IDATA, 32'h00500093);
        chk("f_stalls1", STALLS, 32'd2);
        mack_force = 1'b1;
        run_core(cyc, nrd, nwr, wdat);
        chk("f2_cycles", cyc, 32'd2);
        chk("f2_stalls", STALLS, 32'd4);
        mack_force = 1'b0;

        // load then fetch, 2-wait memory
        RD = 1'b1; DADDR = 32'h2000; wait_cfg = 2;
        run_core(cyc, nrd, nwr, wdat);
        chk("ld_cycles", cyc, 32'd7);
        chk("ld_mrd_cycles", nrd, 32'd6);
        chk("ld_datai", DATAI, 32'hCAFEBABE);
        chk("ld_idata", IDATA, 32'h00500093);
        chk("ld_stalls", STALLS, 32'd11);

        // store then fetch of the same word
        RD = 1'b0; WR = 1'b1; DADDR = 32'h40; DATAO = 32'h12345678; IADDR = 32'h40; wait_cfg = 0;
        wr0 = wr_count;
        run_core(cyc, nrd, nwr, wdat);
        chk("st_cycles", cyc, 32'd3);
        chk("st_mwr_cycles", nwr, 32'd1);
        chk("st_mdatao", wdat, 32'h12345678);
        chk("st_mem_writes", wr_count - wr0, 32'd1);
        chk("st_idata", IDATA, 32'h12345678);
        chk("st_datai_held", DATAI, 32'hCAFEBABE);
        chk("st_err", {31'd0, ERR}, 32'd0);
        chk("st_stalls", STALLS, 32'd14);

        // fetch timeout with TIMEOUT=4
        WR = 1'b0; IADDR = 32'h100; ack_en = 1'b0;
        run_core(cyc, nrd, nwr, wdat);
        chk("to_cycles", cyc, 32'd6);
        chk("to_mrd_cycles", nrd, 32'd5);
        chk("to_idata", IDATA, 32'd0);
        chk("to_err", {31'd0, ERR}, 32'd1);
        chk("to_stalls", STALLS, 32'd20);
        ack_en = 1'b1;
        run_core(cyc, nrd, nwr, wdat);
        chk("to2_idata", IDATA, 32'h00500093);
        chk("to2_err_sticky", {31'd0, ERR}, 32'd1);
        chk("to2_stalls", STALLS, 32'd22);

        // reset during a pending store
        WR = 1'b1; DADDR = 32'h80; DATAO = 32'hA5A5A5A5; ack_en = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rm_mwr_pending", {31'd0, MWR}, 32'd1);
        RESN = 1'b0;
        #1;
        chk("rm_mwr_drop", {31'd0, MWR}, 32'd0);
        chk("rm_hlt", {31'd0, HLT}, 32'd1);
        chk("rm_err", {31'd0, ERR}, 32'd0);
        chk("rm_stalls", STALLS, 32'd0);
        chk("rm_idata", IDATA, 32'd0);
        chk("rm_datai", DATAI, 32'd0);
        WR = 1'b0; HLTI = 1'b1; ack_en = 1'b1;
        @(negedge CLK);
        RESN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("hi_hlt", {31'd0, HLT}, 32'd1);
            chk("hi_strobes", {30'd0, MRD, MWR}, 32'd0);
        end
        chk("hi_stalls", STALLS, 32'd3);
        chk("hi_mem_untouched", mem[8'h20], 32'd0);
        HLTI = 1'b0;
        @(negedge CLK);
        chk("hi_resume_mrd", {31'd0, MRD}, 32'd1);
        chk("hi_resume_maddr", MADDR, 32'h100);
        @(negedge CLK);
        chk("hi_resume_run", {31'd0, HLT}, 32'd0);
        chk("hi_resume_idata", IDATA, 32'h00500093);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
